ariane_axi_cut: RTL and testbench
=================================

Name: ariane_axi_cut

Overview:
- Registered AXI cut on the ariane_axi struct side, directly downstream of the SV-interface-to-struct adapter.
- Breaks every combinational valid/ready/payload path between the adapter output and the crossbar/peripheral slave.
- One two-entry spill register per channel (AW, W, AR forward; B, R backward) gives full throughput with registered outputs.
- Optional per-direction outstanding-transaction limiter.

Parameters:
- Bypass, 0, 1 = all channels combinational passthrough (no registers, no limiter); 0 = registered.
- MaxWrOutstanding, 8, maximum AW handshakes without matching B handshake (limiter only); range 1..255.
- MaxRdOutstanding, 8, maximum AR handshakes without matching last R handshake (limiter only); range 1..255.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous reset, active-high.
- slv_req_i  input  ariane_axi::req_t  request from upstream adapter.
- slv_resp_o  output  ariane_axi::resp_t  response to upstream adapter.
- mst_req_o  output  ariane_axi::req_t  request to downstream slave.
- mst_resp_i  input  ariane_axi::resp_t  response from downstream slave.
- wr_outstanding_o  output  8  current write outstanding count; 0 without macro.
- rd_outstanding_o  output  8  current read outstanding count; 0 without macro.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - All spill entries empty; payload registers cleared to '0.
  - mst_req_o.aw_valid/w_valid/ar_valid = 0; slv_resp_o.b_valid/r_valid = 0.
  - All ready outputs = 1 after reset (buffers empty), except as gated by the limiter.
  - Counters = 0.
- Spill register, per channel: entry A drives the output, entry B is the skid.
  - States: EMPTY (A, B empty), ONE (A full), TWO (A and B full).
  - in_ready = !B_full. This is a registered-only path; no combinational input-ready-to-output-ready path.
  - out_valid = A_full.
  - EMPTY + in fire -> ONE.
  - ONE + in fire + out fire -> ONE (A reloads).
  - ONE + in fire + no out fire -> TWO (data into B).
  - ONE + out fire, no in -> EMPTY.
  - TWO + out fire -> ONE (B moves to A); no in fire possible in TWO.
  - Order strictly preserved. Payload held stable while out_valid && !out_ready.
  - Latency 1 cycle input handshake to output valid. Sustained 1 beat/cycle when downstream ready is held high.
- Payload: entire channel struct (aw, w, ar, b, r fields, including atop and last) is registered unmodified.
- Bypass=1: mst_req_o = slv_req_i, slv_resp_o = mst_resp_i; counters stay 0.
- Async reset mid-operation clears all entries immediately and drops valids within the same cycle. In-flight transactions are discarded; a system-wide reset is required.

Optional Feature:
- Macro: ARIANE_AXI_CUT_OUTSTANDING_EN.
- With the macro:
  - wr counter +1 on slv-side AW handshake; -1 on slv-side B handshake.
  - rd counter +1 on slv-side AR handshake; -1 on slv-side R handshake with r.last=1.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - When wr counter == MaxWrOutstanding, slv_resp_o.aw_ready = 0 and the AW input to the spill register is masked. The same rule applies to AR with MaxRdOutstanding.
  - The counter never exceeds its maximum and never underflows. A decrement at 0 is a protocol error and is flagged by an assertion.
  - W channel is never gated.
- Without the macro: no counters; wr_outstanding_o/rd_outstanding_o tied to 0; AW/AR never gated.

Decomposition:
- Shared package ariane_axi (existing) supplies req_t, resp_t, aw_chan_t, w_chan_t, ar_chan_t, b_chan_t, r_chan_t.
- Add to a package:
  - localparam OutstandingCntWidth = 8.
  - Spill state enum {EMPTY, ONE, TWO}.
- Natural sub-module: ariane_axi_spill_reg, parameterised by payload type, instantiated five times.

Test Plan:
- Single AW addr=0x8000_0000 id=3 len=0 with mst aw_ready=1 -> mst aw_valid asserted exactly 1 cycle after slv handshake, payload bit-identical.
- mst w_ready=0 for 3 cycles, 3 W beats offered back-to-back -> 2 accepted, slv w_ready=0 from the 3rd cycle; after ready rises, beats emerge in order 0,1,2, 3rd accepted 1 cycle later.
- 16-beat R burst with slv r_ready=1 continuously -> 16 beats delivered on 16 consecutive cycles, first beat 1 cycle after mst handshake, r.last only on beat 16.
- Macro on, MaxWrOutstanding=8: 9 AWs offered, no B returned -> 8 accepted, wr_outstanding_o=8, slv aw_ready=0. Then one B returned -> 9th AW accepted on the following cycle, count returns to 8.
- Macro on: AR handshake and last-R handshake in the same cycle at rd count=3 -> count stays 3.
- rst_i asserted while AW entry TWO and R entry ONE -> all valids 0 in the same cycle, readies 1 after release, counters 0.

Source files
------------

// File: rtl/ariane_axi_cut_pkg.sv
// Shared AXI channel types (ariane_axi) and the cut-local constants/types.
// Optional feature macro used by the cut: ARIANE_AXI_CUT_OUTSTANDING_EN.
package ariane_axi;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

package ariane_axi_cut_pkg;
  localparam int unsigned OutstandingCntWidth = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } spill_state_e;
endpackage

// File: rtl/ariane_axi_cut_if.sv
// Request/response bundle between the adapter, the cut and the downstream slave.
interface ariane_axi_cut_if;
  ariane_axi::req_t  req;
  ariane_axi::resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/ariane_axi_cut_spill.sv
// Two-entry spill register: entry A drives the output, entry B is the skid.
// Input ready depends only on state, so no ready path crosses the cut.
module ariane_axi_spill_reg
  import ariane_axi_cut_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);
  spill_state_e r_state;
  T             r_a;
  T             r_b;
  logic         w_in_fire;
  logic         w_out_fire;

  assign o_ready    = (r_state != TWO);
  assign o_valid    = (r_state != EMPTY);
  assign o_data     = r_a;
  assign w_in_fire  = i_valid && o_ready;
  assign w_out_fire = o_valid && i_ready;

  // State and payload update; A always holds the oldest beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_a     <= i_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_a <= i_data;
          end else if (w_in_fire) begin
            r_b     <= i_data;
            r_state <= TWO;
          end else if (w_out_fire) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_a     <= r_b;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/ariane_axi_cut.sv
// Registered AXI cut: one spill register per channel, optional outstanding
// limiter enabled by ARIANE_AXI_CUT_OUTSTANDING_EN.
module ariane_axi_cut
  import ariane_axi::*;
  import ariane_axi_cut_pkg::*;
#(
  parameter bit          Bypass           = 1'b0,
  parameter int unsigned MaxWrOutstanding = 8,
  parameter int unsigned MaxRdOutstanding = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  ariane_axi_cut_if.slave                slv,
  ariane_axi_cut_if.master               mst,
  output logic [OutstandingCntWidth-1:0] wr_outstanding_o,
  output logic [OutstandingCntWidth-1:0] rd_outstanding_o
);
  if (Bypass) begin : g_bypass
    assign mst.req          = slv.req;
    assign slv.resp         = mst.resp;
    assign wr_outstanding_o = '0;
    assign rd_outstanding_o = '0;
  end else begin : g_cut
    logic     w_aw_block, w_ar_block;
    logic     w_aw_vld, w_aw_rdy, w_w_vld, w_w_rdy, w_ar_vld, w_ar_rdy;
    logic     w_b_vld, w_b_rdy, w_r_vld, w_r_rdy;
    aw_chan_t w_aw_dat;
    w_chan_t  w_w_dat;
    ar_chan_t w_ar_dat;
    b_chan_t  w_b_dat;
    r_chan_t  w_r_dat;
    req_t     w_mst_req;
    resp_t    w_slv_resp;

    ariane_axi_spill_reg #(.T(aw_chan_t)) i_aw (
      .clk_i, .rst_i,
      .i_valid(slv.req.aw_valid && !w_aw_block), .o_ready(w_aw_rdy), .i_data(slv.req.aw),
      .o_valid(w_aw_vld), .i_ready(mst.resp.aw_ready), .o_data(w_aw_dat)
    );
    ariane_axi_spill_reg #(.T(w_chan_t)) i_w (
      .clk_i, .rst_i,
      .i_valid(slv.req.w_valid), .o_ready(w_w_rdy), .i_data(slv.req.w),
      .o_valid(w_w_vld), .i_ready(mst.resp.w_ready), .o_data(w_w_dat)
    );
    ariane_axi_spill_reg #(.T(ar_chan_t)) i_ar (
      .clk_i, .rst_i,
      .i_valid(slv.req.ar_valid && !w_ar_block), .o_ready(w_ar_rdy), .i_data(slv.req.ar),
      .o_valid(w_ar_vld), .i_ready(mst.resp.ar_ready), .o_data(w_ar_dat)
    );
    ariane_axi_spill_reg #(.T(b_chan_t)) i_b (
      .clk_i, .rst_i,
      .i_valid(mst.resp.b_valid), .o_ready(w_b_rdy), .i_data(mst.resp.b),
      .o_valid(w_b_vld), .i_ready(slv.req.b_ready), .o_data(w_b_dat)
    );
    ariane_axi_spill_reg #(.T(r_chan_t)) i_r (
      .clk_i, .rst_i,
      .i_valid(mst.resp.r_valid), .o_ready(w_r_rdy), .i_data(mst.resp.r),
      .o_valid(w_r_vld), .i_ready(slv.req.r_ready), .o_data(w_r_dat)
    );

    // Reassemble the registered channels into the outgoing structs.
    always_comb begin
      w_mst_req          = '0;
      w_mst_req.aw       = w_aw_dat;
      w_mst_req.aw_valid = w_aw_vld;
      w_mst_req.w        = w_w_dat;
      w_mst_req.w_valid  = w_w_vld;
      w_mst_req.ar       = w_ar_dat;
      w_mst_req.ar_valid = w_ar_vld;
      w_mst_req.b_ready  = w_b_rdy;
      w_mst_req.r_ready  = w_r_rdy;
      w_slv_resp          = '0;
      w_slv_resp.aw_ready = w_aw_rdy && !w_aw_block;
      w_slv_resp.w_ready  = w_w_rdy;
      w_slv_resp.ar_ready = w_ar_rdy && !w_ar_block;
      w_slv_resp.b_valid  = w_b_vld;
      w_slv_resp.b        = w_b_dat;
      w_slv_resp.r_valid  = w_r_vld;
      w_slv_resp.r        = w_r_dat;
    end

    assign mst.req  = w_mst_req;
    assign slv.resp = w_slv_resp;

`ifdef ARIANE_AXI_CUT_OUTSTANDING_EN
    logic [OutstandingCntWidth-1:0] r_wr_cnt, r_rd_cnt;
    logic w_aw_hs, w_b_hs, w_ar_hs, w_rl_hs;

    assign w_aw_hs    = slv.req.aw_valid && w_slv_resp.aw_ready;
    assign w_b_hs     = w_b_vld && slv.req.b_ready;
    assign w_ar_hs    = slv.req.ar_valid && w_slv_resp.ar_ready;
    assign w_rl_hs    = w_r_vld && slv.req.r_ready && w_r_dat.last;
    assign w_aw_block = (r_wr_cnt == OutstandingCntWidth'(MaxWrOutstanding));
    assign w_ar_block = (r_rd_cnt == OutstandingCntWidth'(MaxRdOutstanding));

    // Write outstanding count: AW handshake in, B handshake out.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_wr_cnt <= '0;
      end else if (w_aw_hs && !w_b_hs && !w_aw_block) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end else if (w_b_hs && !w_aw_hs && (r_wr_cnt != '0)) begin
        r_wr_cnt <= r_wr_cnt - 1'b1;
      end
    end

    // Read outstanding count: AR handshake in, last R handshake out.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_rd_cnt <= '0;
      end else if (w_ar_hs && !w_rl_hs && !w_ar_block) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end else if (w_rl_hs && !w_ar_hs && (r_rd_cnt != '0)) begin
        r_rd_cnt <= r_rd_cnt - 1'b1;
      end
    end

    a_wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_b_hs && !w_aw_hs && (r_wr_cnt == '0)));
    a_rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_rl_hs && !w_ar_hs && (r_rd_cnt == '0)));

    assign wr_outstanding_o = r_wr_cnt;
    assign rd_outstanding_o = r_rd_cnt;
`else
    assign w_aw_block       = 1'b0;
    assign w_ar_block       = 1'b0;
    assign wr_outstanding_o = '0;
    assign rd_outstanding_o = '0;
`endif
  end
endmodule

// File: tb/tb_ariane_axi_cut.sv
// Bench for ariane_axi_cut: each channel is modelled as a two-deep FIFO whose
// input is accepted while fewer than two beats are held (plus the optional
// outstanding limit); directed literal checks pin the model.
module tb_ariane_axi_cut;
  import ariane_axi::*;

  localparam int MAXW = 8;
  localparam int MAXR = 8;

  logic clk;
  logic rst;
  logic [7:0] wr_out, rd_out;

  ariane_axi_cut_if slv_if ();
  ariane_axi_cut_if mst_if ();

  ariane_axi_cut #(
    .Bypass(1'b0),
    .MaxWrOutstanding(MAXW),
    .MaxRdOutstanding(MAXR)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .slv(slv_if),
    .mst(mst_if),
    .wr_outstanding_o(wr_out),
    .rd_outstanding_o(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [255:0] rbits();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: one FIFO per channel (aw, w, ar forward; b, r backward).
  logic [255:0] mq[5][$];
  int wcnt = 0, rcnt = 0;
  int wr_cred = 0, rd_cred = 0;
  string chn[5] = '{"aw", "w", "ar", "b", "r"};

  always @(negedge clk) begin : cmp
    logic         iv[5], ir[5], ov[5], orr[5];
    logic [255:0] idat[5], odat[5];
    bit           er[5], ev[5], inf[5], outf[5];
    r_chan_t      rr;
    bit           rlast_out, rlast_in;
    if (rst) begin
      for (int c = 0; c < 5; c++) mq[c].delete();
      wcnt = 0; rcnt = 0; wr_cred = 0; rd_cred = 0;
    end else begin
      iv[0] = slv_if.req.aw_valid; idat[0] = 256'(slv_if.req.aw); ir[0] = slv_if.resp.aw_ready;
      ov[0] = mst_if.req.aw_valid; odat[0] = 256'(mst_if.req.aw); orr[0] = mst_if.resp.aw_ready;
      iv[1] = slv_if.req.w_valid;  idat[1] = 256'(slv_if.req.w);  ir[1] = slv_if.resp.w_ready;
      ov[1] = mst_if.req.w_valid;  odat[1] = 256'(mst_if.req.w);  orr[1] = mst_if.resp.w_ready;
      iv[2] = slv_if.req.ar_valid; idat[2] = 256'(slv_if.req.ar); ir[2] = slv_if.resp.ar_ready;
      ov[2] = mst_if.req.ar_valid; odat[2] = 256'(mst_if.req.ar); orr[2] = mst_if.resp.ar_ready;
      iv[3] = mst_if.resp.b_valid; idat[3] = 256'(mst_if.resp.b); ir[3] = mst_if.req.b_ready;
      ov[3] = slv_if.resp.b_valid; odat[3] = 256'(slv_if.resp.b); orr[3] = slv_if.req.b_ready;
      iv[4] = mst_if.resp.r_valid; idat[4] = 256'(mst_if.resp.r); ir[4] = mst_if.req.r_ready;
      ov[4] = slv_if.resp.r_valid; odat[4] = 256'(slv_if.resp.r); orr[4] = slv_if.req.r_ready;
      rlast_out = 1'b0;
      if (mq[4].size() > 0) begin
        rr = mq[4][0][$bits(r_chan_t)-1:0];
        rlast_out = rr.last;
      end
      rr = idat[4][$bits(r_chan_t)-1:0];
      rlast_in = rr.last;
      for (int c = 0; c < 5; c++) begin
        er[c] = mq[c].size() < 2;
`ifdef ARIANE_AXI_CUT_OUTSTANDING_EN
        if (c == 0 && wcnt >= MAXW) er[c] = 1'b0;
        if (c == 2 && rcnt >= MAXR) er[c] = 1'b0;
`endif
        ev[c] = mq[c].size() > 0;
        chk({chn[c], "_in_ready"}, 256'(ir[c]), 256'(er[c]));
        chk({chn[c], "_out_valid"}, 256'(ov[c]), 256'(ev[c]));
        if (ev[c]) chk({chn[c], "_out_data"}, odat[c], mq[c][0]);
        inf[c]  = iv[c] && er[c];
        outf[c] = ev[c] && orr[c];
        if (outf[c]) void'(mq[c].pop_front());
        if (inf[c]) mq[c].push_back(idat[c]);
      end
`ifdef ARIANE_AXI_CUT_OUTSTANDING_EN
      chk("wr_outstanding", 256'(wr_out), 256'(wcnt));
      chk("rd_outstanding", 256'(rd_out), 256'(rcnt));
      wcnt = wcnt + int'(inf[0]) - int'(outf[3]);
      rcnt = rcnt + int'(inf[2]) - int'(outf[4] && rlast_out);
`else
      chk("wr_outstanding", 256'(wr_out), 256'(0));
      chk("rd_outstanding", 256'(rd_out), 256'(0));
`endif
      wr_cred = wr_cred + int'(outf[0]) - int'(inf[3]);
      rd_cred = rd_cred + int'(outf[2]) - int'(inf[4] && rlast_in);
    end
  end

  task automatic idle();
    slv_if.req = '0;
    slv_if.req.b_ready = 1'b1;
    slv_if.req.r_ready = 1'b1;
    mst_if.resp = '0;
    mst_if.resp.aw_ready = 1'b1;
    mst_if.resp.w_ready  = 1'b1;
    mst_if.resp.ar_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    idle();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic rand_drive(input int unsigned pv, input int unsigned pr);
    logic [255:0] rb;
    r_chan_t      r;
    rb = rbits(); slv_if.req.aw = rb[$bits(aw_chan_t)-1:0];
    rb = rbits(); slv_if.req.w  = rb[$bits(w_chan_t)-1:0];
    rb = rbits(); slv_if.req.ar = rb[$bits(ar_chan_t)-1:0];
    rb = rbits(); mst_if.resp.b = rb[$bits(b_chan_t)-1:0];
    rb = rbits(); r = rb[$bits(r_chan_t)-1:0];
    if (r.last && rd_cred <= 0) r.last = 1'b0;
    mst_if.resp.r = r;
    slv_if.req.aw_valid  = $urandom_range(99) < pv;
    slv_if.req.w_valid   = $urandom_range(99) < pv;
    slv_if.req.ar_valid  = $urandom_range(99) < pv;
    slv_if.req.b_ready   = $urandom_range(99) < pr;
    slv_if.req.r_ready   = $urandom_range(99) < pr;
    mst_if.resp.aw_ready = $urandom_range(99) < pr;
    mst_if.resp.w_ready  = $urandom_range(99) < pr;
    mst_if.resp.ar_ready = $urandom_range(99) < pr;
    mst_if.resp.b_valid  = ($urandom_range(99) < pv) && (wr_cred > 0);
    mst_if.resp.r_valid  = $urandom_range(99) < pv;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mst_aw_valid"}, 256'(mst_if.req.aw_valid), 256'(0));
    chk({tag, "_mst_w_valid"},  256'(mst_if.req.w_valid),  256'(0));
    chk({tag, "_mst_ar_valid"}, 256'(mst_if.req.ar_valid), 256'(0));
    chk({tag, "_slv_b_valid"},  256'(slv_if.resp.b_valid), 256'(0));
    chk({tag, "_slv_r_valid"},  256'(slv_if.resp.r_valid), 256'(0));
  endtask

  task automatic chk_readies(input string tag);
    chk({tag, "_aw_ready"}, 256'(slv_if.resp.aw_ready), 256'(1));
    chk({tag, "_w_ready"},  256'(slv_if.resp.w_ready),  256'(1));
    chk({tag, "_ar_ready"}, 256'(slv_if.resp.ar_ready), 256'(1));
    chk({tag, "_b_ready"},  256'(mst_if.req.b_ready),   256'(1));
    chk({tag, "_r_ready"},  256'(mst_if.req.r_ready),   256'(1));
    chk({tag, "_wr_cnt"},   256'(wr_out), 256'(0));
    chk({tag, "_rd_cnt"},   256'(rd_out), 256'(0));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk_readies("reset");
    #2 rst = 1'b0;

    // Single AW: registered, visible exactly one cycle after the handshake.
    step();
    slv_if.req.aw_valid   = 1'b1;
    slv_if.req.aw.addr    = 64'h8000_0000;
    slv_if.req.aw.id      = 4'd3;
    slv_if.req.aw.len     = 8'd0;
    slv_if.req.aw.atop    = 6'h2a;
    @(negedge clk);
    chk("aw_accept", 256'(slv_if.resp.aw_ready), 256'(1));
    chk("aw_not_yet", 256'(mst_if.req.aw_valid), 256'(0));
    step();
    slv_if.req.aw_valid = 1'b0;
    @(negedge clk);
    chk("aw_valid_lat1", 256'(mst_if.req.aw_valid), 256'(1));
    chk("aw_addr", 256'(mst_if.req.aw.addr), 256'(64'h8000_0000));
    chk("aw_id", 256'(mst_if.req.aw.id), 256'(3));
    chk("aw_atop", 256'(mst_if.req.aw.atop), 256'(6'h2a));
    step();
    @(negedge clk);
    chk("aw_drained", 256'(mst_if.req.aw_valid), 256'(0));

    // W backpressure: two beats absorbed, third waits for a free entry.
    mst_if.resp.w_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      slv_if.req.w_valid = 1'b1;
      slv_if.req.w.data  = 64'(i);
      slv_if.req.w.last  = (i == 2);
      @(negedge clk);
      chk($sformatf("w_bp_ready%0d", i), 256'(slv_if.resp.w_ready), 256'(i < 2));
    end
    step();
    mst_if.resp.w_ready = 1'b1;
    @(negedge clk);
    chk("w_out0", 256'(mst_if.req.w.data), 256'(0));
    chk("w_ready_still0", 256'(slv_if.resp.w_ready), 256'(0));
    step();
    @(negedge clk);
    chk("w_out1", 256'(mst_if.req.w.data), 256'(1));
    chk("w_third_accept", 256'(slv_if.resp.w_ready), 256'(1));
    step();
    slv_if.req.w_valid = 1'b0;
    @(negedge clk);
    chk("w_out2", 256'(mst_if.req.w.data), 256'(2));
    chk("w_out2_valid", 256'(mst_if.req.w_valid), 256'(1));

    // One AR, then a 16-beat R burst streamed at full rate.
    step();
    slv_if.req.ar_valid = 1'b1;
    slv_if.req.ar.len   = 8'd15;
    step();
    slv_if.req.ar_valid = 1'b0;
    step();
    for (int i = 0; i <= 16; i++) begin
      step();
      mst_if.resp.r_valid = (i < 16);
      mst_if.resp.r.data  = 64'(i);
      mst_if.resp.r.last  = (i == 15);
      @(negedge clk);
      if (i == 0) chk("r_first_not_yet", 256'(slv_if.resp.r_valid), 256'(0));
      else begin
        chk($sformatf("r_valid%0d", i - 1), 256'(slv_if.resp.r_valid), 256'(1));
        chk($sformatf("r_data%0d", i - 1), 256'(slv_if.resp.r.data), 256'(i - 1));
        chk($sformatf("r_last%0d", i - 1), 256'(slv_if.resp.r.last), 256'(i == 16));
      end
    end
    step();
    @(negedge clk);
    chk("r_burst_done", 256'(slv_if.resp.r_valid), 256'(0));

`ifdef ARIANE_AXI_CUT_OUTSTANDING_EN
    // Write limit: nine AWs offered, eight accepted until one B returns.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      slv_if.req.aw_valid = 1'b1;
    end
    @(negedge clk);
    chk("lim_wr_full", 256'(wr_out), 256'(MAXW));
    chk("lim_aw_blocked", 256'(slv_if.resp.aw_ready), 256'(0));
    step();
    mst_if.resp.b_valid = 1'b1;
    step();
    mst_if.resp.b_valid = 1'b0;
    @(negedge clk);
    chk("lim_b_ret", 256'(slv_if.resp.b_valid), 256'(1));
    chk("lim_cnt_before_b", 256'(wr_out), 256'(MAXW));
    step();
    @(negedge clk);
    chk("lim_aw_reopen", 256'(slv_if.resp.aw_ready), 256'(1));
    chk("lim_cnt_after_b", 256'(wr_out), 256'(MAXW - 1));
    step();
    slv_if.req.aw_valid = 1'b0;
    @(negedge clk);
    chk("lim_cnt_refull", 256'(wr_out), 256'(MAXW));

    // Simultaneous AR handshake and last-R handshake leave the count alone.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      slv_if.req.ar_valid = 1'b1;
    end
    step();
    slv_if.req.ar_valid = 1'b0;
    mst_if.resp.r_valid = 1'b1;
    mst_if.resp.r.last  = 1'b1;
    step();
    mst_if.resp.r_valid = 1'b0;
    slv_if.req.ar_valid = 1'b1;
    @(negedge clk);
    chk("lim_rd3", 256'(rd_out), 256'(3));
    chk("lim_r_last_out", 256'(slv_if.resp.r_valid && slv_if.resp.r.last), 256'(1));
    step();
    slv_if.req.ar_valid = 1'b0;
    @(negedge clk);
    chk("lim_rd_same", 256'(rd_out), 256'(3));
`endif

    // Async reset while AW holds two beats and R holds one.
    do_reset();
    mst_if.resp.aw_ready = 1'b0;
    slv_if.req.r_ready   = 1'b0;
    step();
    slv_if.req.aw_valid = 1'b1;
    mst_if.resp.r_valid = 1'b1;
    mst_if.resp.r.last  = 1'b0;
    step();
    mst_if.resp.r_valid = 1'b0;
    step();
    slv_if.req.aw_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_aw_full", 256'(slv_if.resp.aw_ready), 256'(0));
    chk("pre_rst_r_valid", 256'(slv_if.resp.r_valid), 256'(1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_quiet("midrst");
    idle();
    @(negedge clk);
    #2 rst = 1'b0;
    step();
    @(negedge clk);
    chk_readies("postrst");

    // Randomised traffic at several densities.
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 1000; n++) begin
        step();
        case (p)
          0:       rand_drive(50, 70);
          1:       rand_drive(90, 95);
          default: rand_drive(30, 30);
        endcase
      end
    end
    step();
    idle();
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
